// File: rtl/tuner_pkg.sv
// Shared definitions for the tone-generator front end.
// Contents:
//   - note codes that match the square-wave generator LUT
//   - bit positions of the fields in a song entry, and the end-of-song marker
//   - state encoding of the note sequencer
//   - song_entry(): packs one song table word
package tuner_pkg;

  localparam logic [2:0] NOTE_C  = 3'd0;
  localparam logic [2:0] NOTE_D  = 3'd1;
  localparam logic [2:0] NOTE_E  = 3'd2;
  localparam logic [2:0] NOTE_F  = 3'd3;
  localparam logic [2:0] NOTE_G  = 3'd4;
  localparam logic [2:0] NOTE_A  = 3'd5;
  localparam logic [2:0] NOTE_B  = 3'd6;
  localparam logic [2:0] NOTE_C5 = 3'd7;

  // Song entry layout: [7:5] note, [4] rest, [3:0] duration units.
  localparam int NOTE_MSB  = 7;
  localparam int NOTE_LSB  = 5;
  localparam int REST_BIT  = 4;
  localparam int UNITS_MSB = 3;
  localparam int UNITS_LSB = 0;

  // A duration of zero units marks the end of the song.
  localparam logic [3:0] END_UNITS = 4'd0;
  localparam logic [7:0] END_ENTRY = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_PLAY   = 3'd3,
    S_GAP    = 3'd4,
    S_FINISH = 3'd5
  } seq_state_t;

  function automatic logic [7:0] song_entry(input logic [2:0] note,
                                            input logic       rest,
                                            input logic [3:0] units);
    return {note, rest, units};
  endfunction

endpackage

// File: rtl/song_rom.sv
// Song table: SONG_LEN x 8-bit constant table with a one-clock registered read.
// SONG_ID picks one of the built-in tables:
//   0 = demo melody, 1 = one note then END, 2 = rest + note then END,
//   3 = full table with no END marker (entry i plays note i mod 8 for 1 unit).
// Ports:
//   clk   in   system clock
//   addr  in   table address (ADDR_W bits)
//   data  out  entry at the address presented on the previous clock
module song_rom
  import tuner_pkg::*;
#(
  parameter int SONG_LEN = 16,
  parameter int ADDR_W   = $clog2(SONG_LEN),
  parameter int SONG_ID  = 0
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        data
);

  logic [7:0] data_r;

  function automatic logic [7:0] lookup(input int a);
    logic [7:0] w;
    w = END_ENTRY;
    case (SONG_ID)
      32'd1: begin
        case (a)
          32'd0:   w = song_entry(NOTE_F, 1'b0, 4'd2);
          default: w = END_ENTRY;
        endcase
      end
      32'd2: begin
        case (a)
          32'd0:   w = song_entry(NOTE_A, 1'b1, 4'd1);
          32'd1:   w = song_entry(NOTE_E, 1'b0, 4'd1);
          default: w = END_ENTRY;
        endcase
      end
      32'd3: w = song_entry(3'(a), 1'b0, 4'd1);
      default: begin
        case (a)
          32'd0:   w = song_entry(NOTE_E, 1'b0, 4'd2);
          32'd1:   w = song_entry(NOTE_E, 1'b0, 4'd2);
          32'd2:   w = song_entry(NOTE_F, 1'b0, 4'd2);
          32'd3:   w = song_entry(NOTE_G, 1'b0, 4'd2);
          32'd4:   w = song_entry(NOTE_G, 1'b0, 4'd2);
          32'd5:   w = song_entry(NOTE_F, 1'b0, 4'd2);
          32'd6:   w = song_entry(NOTE_E, 1'b0, 4'd2);
          32'd7:   w = song_entry(NOTE_D, 1'b0, 4'd2);
          32'd8:   w = song_entry(NOTE_C, 1'b0, 4'd2);
          32'd9:   w = song_entry(NOTE_C, 1'b0, 4'd2);
          32'd10:  w = song_entry(NOTE_D, 1'b0, 4'd2);
          32'd11:  w = song_entry(NOTE_E, 1'b0, 4'd2);
          32'd12:  w = song_entry(NOTE_E, 1'b0, 4'd3);
          32'd13:  w = song_entry(NOTE_D, 1'b0, 4'd1);
          32'd14:  w = song_entry(NOTE_D, 1'b0, 4'd4);
          default: w = END_ENTRY;
        endcase
      end
    endcase
    return w;
  endfunction

  // Registered table read.
  always_ff @(posedge clk) begin
    data_r <= lookup(int'(addr));
  end

  assign data = data_r;

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: walks the song table and drives the tone generator's note
// select and enable. Each entry sounds for units*UNIT_TICKS audio strobes and
// is followed by GAP_TICKS silent strobes.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-low reset
//   clk_aud  in   audio sample strobe, one clk wide
//   start    in   begin playback from entry 0 (honoured only when idle)
//   stop     in   abort playback (wins over everything except reset)
//   loop     in   at end of song: 1 = restart from entry 0
//   select   out  note code to tone generator
//   enable   out  tone generator enable
//   busy     out  high in every state except IDLE
//   index    out  current song table address
//   done     out  one-clk pulse at end of song
module note_sequencer
  import tuner_pkg::*;
#(
  parameter  int SONG_LEN   = 16,
  parameter  int UNIT_TICKS = 6000,
  parameter  int GAP_TICKS  = 480,
  parameter  int SONG_ID    = 0,
  localparam int ADDR_W     = $clog2(SONG_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_aud,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic [2:0]        select,
  output logic              enable,
  output logic              busy,
  output logic [ADDR_W-1:0] index,
  output logic              done
);

  localparam int TICK_W = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
  localparam int GAP_W  = $clog2(GAP_TICKS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(UNIT_TICKS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(GAP_TICKS - 1);
  localparam logic [ADDR_W-1:0] INDEX_LAST = ADDR_W'(SONG_LEN - 1);

  seq_state_t        state_r;
  logic [2:0]        select_r;
  logic              enable_r;
  logic              busy_r;
  logic              done_r;
  logic [ADDR_W-1:0] index_r;
  logic [TICK_W-1:0] tick_cnt_r;
  logic [3:0]        unit_cnt_r;
  logic [GAP_W-1:0]  gap_cnt_r;

  logic [7:0]        rom_word_s;
  logic [2:0]        entry_note_s;
  logic              entry_rest_s;
  logic [3:0]        entry_units_s;

  // The ROM is addressed straight from index_r, so the word for the entry
  // selected in FETCH is valid when the FSM reaches LOAD.
  song_rom #(
    .SONG_LEN (SONG_LEN),
    .ADDR_W   (ADDR_W),
    .SONG_ID  (SONG_ID)
  ) u_song_rom (
    .clk  (clk),
    .addr (index_r),
    .data (rom_word_s)
  );

  assign entry_note_s  = rom_word_s[NOTE_MSB:NOTE_LSB];
  assign entry_rest_s  = rom_word_s[REST_BIT];
  assign entry_units_s = rom_word_s[UNITS_MSB:UNITS_LSB];

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      select_r   <= 3'd0;
      enable_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      index_r    <= '0;
      tick_cnt_r <= '0;
      unit_cnt_r <= 4'd0;
      gap_cnt_r  <= '0;
    end else if (stop && (state_r != S_IDLE)) begin
      // Abort: silent return to IDLE, no done pulse.
      state_r    <= S_IDLE;
      select_r   <= 3'd0;
      enable_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      index_r    <= '0;
      tick_cnt_r <= '0;
      unit_cnt_r <= 4'd0;
      gap_cnt_r  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start && !stop) begin
            state_r <= S_FETCH;
            index_r <= '0;
            busy_r  <= 1'b1;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_FETCH: begin
          state_r <= S_LOAD;
        end
        S_LOAD: begin
          if (entry_units_s == END_UNITS) begin
            state_r  <= S_FINISH;
            enable_r <= 1'b0;
            done_r   <= 1'b1;
          end else begin
            state_r    <= S_PLAY;
            select_r   <= entry_note_s;
            enable_r   <= ~entry_rest_s;
            unit_cnt_r <= entry_units_s;
            tick_cnt_r <= '0;
          end
        end
        S_PLAY: begin
          if (clk_aud) begin
            if (tick_cnt_r == TICK_LAST) begin
              tick_cnt_r <= '0;
              unit_cnt_r <= unit_cnt_r - 4'd1;
              // Last unit just completed: sounding time is exactly units*UNIT_TICKS.
              if (unit_cnt_r == 4'd1) begin
                state_r   <= S_GAP;
                enable_r  <= 1'b0;
                gap_cnt_r <= '0;
              end else begin
                state_r <= S_PLAY;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + TICK_W'(1);
            end
          end else begin
            state_r <= S_PLAY;
          end
        end
        S_GAP: begin
          if (clk_aud) begin
            if (gap_cnt_r == GAP_LAST) begin
              gap_cnt_r <= '0;
              if (index_r == INDEX_LAST) begin
                state_r <= S_FINISH;
                done_r  <= 1'b1;
              end else begin
                state_r <= S_FETCH;
                index_r <= index_r + ADDR_W'(1);
              end
            end else begin
              gap_cnt_r <= gap_cnt_r + GAP_W'(1);
            end
          end else begin
            state_r <= S_GAP;
          end
        end
        S_FINISH: begin
          index_r <= '0;
          if (loop) begin
            state_r <= S_FETCH;
          end else begin
            state_r  <= S_IDLE;
            select_r <= 3'd0;
            busy_r   <= 1'b0;
          end
        end
        default: begin
          state_r  <= S_IDLE;
          select_r <= 3'd0;
          enable_r <= 1'b0;
          busy_r   <= 1'b0;
          index_r  <= '0;
        end
      endcase
    end
  end

  assign select = select_r;
  assign enable = enable_r;
  assign busy   = busy_r;
  assign index  = index_r;
  assign done   = done_r;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer. Three instances share clk, clk_aud,
// reset and stop; each plays a different built-in table and has its own start.
// Expected values are queued when stimulus is applied and popped as the DUT
// produces the corresponding output.
module tb_note_sequencer;

  localparam int SONG_LEN   = 16;
  localparam int ADDR_W     = 4;
  localparam int UNIT_TICKS = 4;
  localparam int GAP_TICKS  = 2;

  logic clk, reset, clk_aud, stop, loop, start1, start2, start3;
  logic [2:0] sel1, sel2, sel3;
  logic en1, en2, en3, busy1, busy2, busy3, done1, done2, done3;
  logic [ADDR_W-1:0] idx1, idx2, idx3;

  note_sequencer #(.SONG_LEN(SONG_LEN), .UNIT_TICKS(UNIT_TICKS), .GAP_TICKS(GAP_TICKS), .SONG_ID(1)) u_dut1 (
    .clk(clk), .reset(reset), .clk_aud(clk_aud), .start(start1), .stop(stop), .loop(loop),
    .select(sel1), .enable(en1), .busy(busy1), .index(idx1), .done(done1));
  note_sequencer #(.SONG_LEN(SONG_LEN), .UNIT_TICKS(UNIT_TICKS), .GAP_TICKS(GAP_TICKS), .SONG_ID(2)) u_dut2 (
    .clk(clk), .reset(reset), .clk_aud(clk_aud), .start(start2), .stop(stop), .loop(loop),
    .select(sel2), .enable(en2), .busy(busy2), .index(idx2), .done(done2));
  note_sequencer #(.SONG_LEN(SONG_LEN), .UNIT_TICKS(UNIT_TICKS), .GAP_TICKS(GAP_TICKS), .SONG_ID(3)) u_dut3 (
    .clk(clk), .reset(reset), .clk_aud(clk_aud), .start(start3), .stop(stop), .loop(loop),
    .select(sel3), .enable(en3), .busy(busy3), .index(idx3), .done(done3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Audio strobe: high for one clk out of every three, changing 1 time unit after posedge.
  int aud_ph;
  initial begin
    clk_aud = 1'b0;
    aud_ph  = 0;
    forever begin
      @(posedge clk);
      #1;
      clk_aud = (aud_ph == 2);
      aud_ph  = (aud_ph + 1) % 3;
    end
  end

  // Observation mux for the instance under test.
  int cur;
  logic [2:0] o_sel;
  logic o_en, o_busy, o_done;
  logic [ADDR_W-1:0] o_idx;
  logic [9:0] o_outs;
  always_comb begin
    o_sel = sel1; o_en = en1; o_busy = busy1; o_idx = idx1; o_done = done1;
    if (cur == 2) begin
      o_sel = sel2; o_en = en2; o_busy = busy2; o_idx = idx2; o_done = done2;
    end else if (cur == 3) begin
      o_sel = sel3; o_en = en3; o_busy = busy3; o_idx = idx3; o_done = done3;
    end
  end
  assign o_outs = {o_sel, o_en, o_busy, o_idx, o_done};

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int n_cmp;
  int n_fail;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %0h, nothing queued", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int cnt, k, w, dones, rises, bad, dn;
  logic prev_en, prev_done, en_seen, sel_bad;

  initial begin
    n_cmp = 0; n_fail = 0; cur = 1;
    reset = 1'b0; stop = 1'b0; loop = 1'b0;
    start1 = 1'b1; start2 = 1'b1; start3 = 1'b1;

    // Reset held with start asserted: all three instances stay at reset values.
    for (int i = 0; i < 3; i++) begin
      push("reset_outs", 32'd0);
      tick();
      check({2'b00, sel1, en1, busy1, idx1, done1, sel2, en2, busy2, idx2, done2,
             sel3, en3, busy3, idx3, done3});
    end
    reset = 1'b1; start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
    tick();

    // Single note {F=3, units 2} then END.
    cur = 1;
    push("sn_busy", 32'd1); push("sn_sel", 32'd3); push("sn_en", 32'd1);
    push("sn_sound_strobes", 32'd8); push("sn_gap_strobes", 32'd2);
    push("sn_done_width", 32'd1); push("sn_after_outs", 32'd0);
    start1 = 1'b1; tick(); start1 = 1'b0;
    check(o_busy);
    tick(); tick();
    check(o_sel); check(o_en);
    cnt = 0; k = 0;
    while (o_en === 1'b1 && k < 200) begin
      if (clk_aud) cnt++;
      tick(); k++;
    end
    check(cnt);
    cnt = 0; k = 0;
    while (o_done !== 1'b1 && k < 200) begin
      if (clk_aud) cnt++;
      tick(); k++;
    end
    check(cnt);
    w = 0; k = 0;
    while (o_done === 1'b1 && k < 10) begin
      w++; tick(); k++;
    end
    check(w);
    check(o_outs);

    // Rest entry {A=5, rest, units 1}: silent for 4+2 strobes, then index 1.
    cur = 2;
    push("rs_sel", 32'd5); push("rs_en", 32'd0); push("rs_strobes", 32'd6);
    push("rs_en_seen", 32'd0); push("rs_sel_bad", 32'd0); push("rs_idx", 32'd1);
    push("rs_idle", 32'd0);
    start2 = 1'b1; tick(); start2 = 1'b0;
    tick(); tick();
    check(o_sel); check(o_en);
    cnt = 0; k = 0; en_seen = 1'b0; sel_bad = 1'b0;
    while (o_idx == 4'd0 && k < 200) begin
      if (o_en !== 1'b0) en_seen = 1'b1;
      if (o_sel !== 3'd5) sel_bad = 1'b1;
      if (clk_aud) cnt++;
      tick(); k++;
    end
    check(cnt); check(en_seen); check(sel_bad); check(o_idx);
    k = 0;
    while (o_busy === 1'b1 && k < 200) begin
      tick(); k++;
    end
    check(o_busy);

    // Loop over the two-entry song for three passes.
    cur = 2; loop = 1'b1;
    push("lp_dones", 32'd3); push("lp_note_rises", 32'd3);
    push("lp_restart_bad", 32'd0); push("lp_idle", 32'd0);
    start2 = 1'b1; tick(); start2 = 1'b0;
    dones = 0; rises = 0; bad = 0; k = 0; prev_en = 1'b0; prev_done = 1'b0;
    while (o_busy === 1'b1 && k < 2000) begin
      if (prev_done && !(o_idx == 4'd0 && o_busy === 1'b1)) bad++;
      if (prev_done && dones == 2) loop = 1'b0;
      if (o_en === 1'b1 && !prev_en && o_sel == 3'd2) rises++;
      if (o_done === 1'b1) dones++;
      prev_en = o_en; prev_done = o_done;
      tick(); k++;
    end
    loop = 1'b0;
    check(dones); check(rises); check(bad); check(o_busy);

    // Stop during PLAY of entry 2 of the full table.
    cur = 3;
    push("st_pre_en", 32'd1); push("st_outs", 32'd0); push("st_no_done", 32'd0);
    push("ss_busy", 32'd0); push("ss_busy_later", 32'd0);
    start3 = 1'b1; tick(); start3 = 1'b0;
    k = 0;
    while (!(o_idx == 4'd2 && o_en === 1'b1) && k < 500) begin
      tick(); k++;
    end
    tick(); tick();
    check(o_en);
    stop = 1'b1; tick(); stop = 1'b0;
    check(o_outs);
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      if (o_done === 1'b1) dn++;
      tick();
    end
    check(dn);
    start3 = 1'b1; stop = 1'b1; tick(); start3 = 1'b0; stop = 1'b0;
    check(o_busy);
    tick();
    check(o_busy);

    // Full table, no END marker: done after entry 15's gap, then index 0.
    cur = 3;
    push("ft_note_rises", 32'd16); push("ft_sel_bad", 32'd0); push("ft_done_idx", 32'd15);
    push("ft_after_idx", 32'd0); push("ft_after_busy", 32'd0);
    start3 = 1'b1; tick(); start3 = 1'b0;
    rises = 0; bad = 0; k = 0; prev_en = 1'b0;
    while (o_done !== 1'b1 && k < 3000) begin
      if (o_en === 1'b1 && !prev_en) begin
        rises++;
        if (o_sel !== o_idx[2:0]) bad++;
      end
      prev_en = o_en;
      tick(); k++;
    end
    check(rises); check(bad); check(o_idx);
    tick();
    check(o_idx); check(o_busy);

    // Reset asserted while in GAP.
    push("rg_in_gap", 32'd2); push("rg_outs", 32'd0); push("rg_idle", 32'd0);
    start3 = 1'b1; tick(); start3 = 1'b0;
    prev_en = 1'b0; k = 0;
    while (!(prev_en && o_en === 1'b0) && k < 500) begin
      prev_en = o_en;
      tick(); k++;
    end
    tick();
    check({o_busy, o_en});
    reset = 1'b0; tick(); reset = 1'b1;
    check(o_outs);
    tick();
    check(o_outs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
